picomips_core: RTL and testbench
================================

# picomips_core

Multicycle, parametrised successor to the single-cycle picoMIPS CPU. Fetches N+16-bit instructions from an external synchronous program ROM and executes a small ALU/branch ISA with an R0-is-zero register file. Adds data-memory load/store over a req/ready handshake, an input port, a registered output port, Z/C flags and a HALT state. Sits at the top of the picoMIPS hierarchy in place of the single-cycle CPU; ROM and RAM live outside.

## Interface
- N, 8: data width, 4 or more.
- PSIZE, 6: program address width, so 2^PSIZE instructions.
- ISIZE, N+16: instruction width, derived and not overridable.
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the core.
- imem_addr  out  PSIZE  program ROM address, equal to PC.
- imem_data  in  ISIZE  ROM word, valid one cycle after imem_addr.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_addr  out  N  data address.
- dmem_wdata  out  N  store data.
- dmem_rdata  in  N  load data, sampled when dmem_req && dmem_ready.
- dmem_ready  in  1  access completes this cycle.
- inport  in  N  general input, sampled by IN.
- outport  out  N  registered output, written by OUT.
- halted  out  1  high while in HALT.

## Operation
- Instruction fields: op = [ISIZE-1:ISIZE-6], rd = [ISIZE-7:ISIZE-11], rs = [ISIZE-12:ISIZE-16], imm = [N-1:0]. 32 registers of N bits. R0 reads 0, and writes to R0 are discarded.
- ALU ops write rd = rd op B. B is R[rs] for register forms and imm for immediate forms.
  - ADD 01 / ADDI 09: C = carry-out.
  - SUB 02 / SUBI 0A: C = borrow, i.e. rd < B unsigned.
  - AND 03 / ANDI 0B, OR 04 / ORI 0C, XOR 05 / XORI 0D: C = 0.
  - All ALU ops set Z = (result == 0). Results wrap modulo 2^N.
- Other opcodes:
  - NOP 00.
  - LDI 0E: rd = imm. Flags unchanged.
  - LW 10: rd = mem[R[rs]+imm].
  - SW 11: mem[R[rs]+imm] = R[rd]. Address sum wraps modulo 2^N.
  - IN 12: rd = inport.
  - OUT 13: outport = R[rd].
  - BEQ 20: branch if Z. BNE 21: branch if !Z. J 22: unconditional. Target = imm[PSIZE-1:0].
  - HALT 3F.
  - Any other opcode executes as NOP.
- Only ALU ops change flags.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH drives imem_addr = PC, then goes to EXEC.
  - EXEC decodes imem_data:
    - ALU, LDI, IN, OUT, NOP: commit, PC += 1, go to FETCH.
    - Branch: PC = target if taken, else PC + 1; go to FETCH.
    - LW/SW: latch address and data, go to MEM.
    - HALT: go to HALT with PC unchanged.
  - MEM holds dmem_req = 1 with dmem_we, addr and wdata stable until dmem_ready. On that edge it commits (LW writes rd), sets PC += 1 and goes to FETCH.
  - HALT is left only by reset.
- PC increments modulo 2^PSIZE, so 2^PSIZE-1 wraps to 0.
- dmem_req is low outside MEM. dmem_we is 0 when dmem_req is low.

## Timing
- Reset values: PC = 0, state = FETCH, Z = C = 0, outport = 0, halted = 0, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0, imem_addr = 0. Register file R1..R31 is not reset.
- Reset mid-access: dmem_req falls in the cycle after the reset edge, the access is abandoned and no register is written.
- Cycles per instruction:
  - Non-memory instructions and branches: 2.
  - LW/SW: 2 + k, where k ≥ 1 is the number of MEM cycles up to and including the one with dmem_ready high.
  - A ready already high on the first MEM cycle gives 3.
- Register, flag and outport writes become visible on the EXEC (or final MEM) edge. The next instruction's EXEC sees them, so there are no hazards.
- halted rises on the edge that leaves EXEC with HALT.
- dmem_ready is ignored when dmem_req is low.

## Test plan
- Reset then LDI R1,5; LDI R2,3; ADD R1,R2; OUT R1 -> outport = 8 after 8 cycles, Z = 0, C = 0.
- N=8: LDI R1,0xFF; ADDI R1,1 -> R1 = 0, Z = 1, C = 1. Then SUBI R1,1 -> R1 = 0xFF, C = 1, Z = 0.
- Loop: LDI R1,3; SUBI R1,1; BNE to SUBI; HALT -> BNE taken twice, falls through once, halted = 1, PC frozen.
- SW R3 to address R4+2 with ready delayed 3 cycles -> req/we/addr/wdata held stable for 3 MEM cycles, one write; a following LW to the same address with immediate ready returns the same value in 3 cycles.
- LDI R0,7; OUT R0 -> outport = 0. Unknown opcode 15 -> PC += 1, no state change. PC at 63 (PSIZE=6) with NOP -> next fetch from address 0.
- Assert reset during MEM with ready low -> next cycle dmem_req = 0, PC = 0, state FETCH; the load target register is unchanged.

Source files
------------

// File: rtl/picomips_core.sv
// Multicycle picoMIPS core: fetch/execute over a synchronous program ROM, R0-is-zero
// register file, Z/C flags, data memory over a req/ready handshake, and a HALT state.
module picomips_core #(
    parameter int N = 8,
    parameter int PSIZE = 6,
    localparam int ISIZE = N + 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PSIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [N-1:0]     dmem_addr,
    output logic [N-1:0]     dmem_wdata,
    input  logic [N-1:0]     dmem_rdata,
    input  logic             dmem_ready,
    input  logic [N-1:0]     inport,
    output logic [N-1:0]     outport,
    output logic             halted
);

    // state | meaning
    // FETCH | PC drives the ROM address; ROM word arrives for EXEC
    // EXEC  | decode and commit, or latch a memory access
    // MEM   | hold the data request until dmem_ready
    // HALT  | frozen until reset
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [5:0] OP_LDI  = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h10;
    localparam logic [5:0] OP_SW   = 6'h11;
    localparam logic [5:0] OP_IN   = 6'h12;
    localparam logic [5:0] OP_OUT  = 6'h13;
    localparam logic [5:0] OP_BEQ  = 6'h20;
    localparam logic [5:0] OP_BNE  = 6'h21;
    localparam logic [5:0] OP_J    = 6'h22;
    localparam logic [5:0] OP_HALT = 6'h3F;

    state_t           state, state_nx;
    logic [PSIZE-1:0] pc, pc_nx;
    logic             z, z_nx, c, c_nx;
    logic [N-1:0]     out_r, out_nx;
    logic             mem_we_r, mem_we_nx;
    logic [N-1:0]     mem_addr_r, mem_addr_nx;
    logic [N-1:0]     mem_wdata_r, mem_wdata_nx;
    logic [4:0]       mem_rd_r, mem_rd_nx;

    logic [N-1:0]     regs [32];
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [N-1:0]     rf_wdata;

    logic [5:0]       op;
    logic [4:0]       rd, rs;
    logic [N-1:0]     imm, ra, rb, b_op, alu_res;
    logic [N:0]       sum, diff;
    logic             alu_c, is_alu;

    assign op  = imem_data[ISIZE-1 -: 6];
    assign rd  = imem_data[ISIZE-7 -: 5];
    assign rs  = imem_data[ISIZE-12 -: 5];
    assign imm = imem_data[N-1:0];
    assign ra  = (rd == 5'd0) ? '0 : regs[rd];
    assign rb  = (rs == 5'd0) ? '0 : regs[rs];

    // Register and immediate ALU forms share the low three opcode bits; bit 3 picks imm.
    assign is_alu = (op[5:4] == 2'b00) && (op[2:0] >= 3'd1) && (op[2:0] <= 3'd5);

    always_comb begin
        b_op    = op[3] ? imm : rb;
        sum     = {1'b0, ra} + {1'b0, b_op};
        diff    = {1'b0, ra} - {1'b0, b_op};
        alu_res = '0;
        alu_c   = 1'b0;
        case (op[2:0])
            3'd1:    {alu_c, alu_res} = sum;
            3'd2:    {alu_c, alu_res} = diff;
            3'd3:    alu_res = ra & b_op;
            3'd4:    alu_res = ra | b_op;
            3'd5:    alu_res = ra ^ b_op;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        z_nx         = z;
        c_nx         = c;
        out_nx       = out_r;
        mem_we_nx    = mem_we_r;
        mem_addr_nx  = mem_addr_r;
        mem_wdata_nx = mem_wdata_r;
        mem_rd_nx    = mem_rd_r;
        rf_we        = 1'b0;
        rf_waddr     = rd;
        rf_wdata     = alu_res;
        case (state)
            S_FETCH: state_nx = S_EXEC;
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc + PSIZE'(1);
                if (is_alu) begin
                    rf_we = 1'b1;
                    z_nx  = (alu_res == '0);
                    c_nx  = alu_c;
                end
                case (op)
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm;
                    end
                    OP_IN: begin
                        rf_we    = 1'b1;
                        rf_wdata = inport;
                    end
                    OP_OUT: out_nx = ra;
                    OP_BEQ: if (z) pc_nx = imm[PSIZE-1:0];
                    OP_BNE: if (!z) pc_nx = imm[PSIZE-1:0];
                    OP_J:   pc_nx = imm[PSIZE-1:0];
                    OP_LW, OP_SW: begin
                        state_nx     = S_MEM;
                        pc_nx        = pc;
                        mem_we_nx    = (op == OP_SW);
                        mem_addr_nx  = rb + imm;
                        mem_wdata_nx = ra;
                        mem_rd_nx    = rd;
                    end
                    OP_HALT: begin
                        state_nx = S_HALT;
                        pc_nx    = pc;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_nx = S_FETCH;
                    pc_nx    = pc + PSIZE'(1);
                    if (!mem_we_r) begin
                        rf_we    = 1'b1;
                        rf_waddr = mem_rd_r;
                        rf_wdata = dmem_rdata;
                    end
                end
            end
            default: state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FETCH;
            pc          <= '0;
            z           <= 1'b0;
            c           <= 1'b0;
            out_r       <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_rd_r    <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            z           <= z_nx;
            c           <= c_nx;
            out_r       <= out_nx;
            mem_we_r    <= mem_we_nx;
            mem_addr_r  <= mem_addr_nx;
            mem_wdata_r <= mem_wdata_nx;
            mem_rd_r    <= mem_rd_nx;
        end
    end

    // Register file is not cleared, but reset still blocks a pending write.
    always_ff @(posedge clk) begin
        if (reset && rf_we && (rf_waddr != 5'd0))
            regs[rf_waddr] <= rf_wdata;
    end

    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = dmem_req & mem_we_r;
    assign dmem_addr  = mem_addr_r;
    assign dmem_wdata = mem_wdata_r;
    assign outport    = out_r;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_picomips_core.sv
// Self-checking bench for picomips_core: an instruction-level ISA model drives the
// expectations; ROM and RAM are modelled here with a randomised-latency data port.
module tb_picomips_core;
    localparam int N = 8;
    localparam int PSIZE = 6;
    localparam int ISIZE = 24;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [PSIZE-1:0] imem_addr;
    logic [ISIZE-1:0] imem_data = '0;
    logic             dmem_req, dmem_we;
    logic [N-1:0]     dmem_addr, dmem_wdata;
    logic [N-1:0]     dmem_rdata = '0;
    logic             dmem_ready = 1'b0;
    logic [N-1:0]     inport = '0;
    logic [N-1:0]     outport;
    logic             halted;

    picomips_core #(.N(N), .PSIZE(PSIZE)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .inport(inport), .outport(outport), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [ISIZE-1:0] rom [64];
    logic [7:0]       mem [256];
    always @(posedge clk) imem_data <= rom[imem_addr];

    // Data port responder: ready in the k-th request cycle, noise on ready while idle.
    int   mem_k = 1;
    bit   mon_en = 0;
    bit   in_acc = 0;
    int   acc_cnt = 0;
    int   unstable = 0;
    int   we_viol = 0;
    int   wr_cnt = 0;
    logic [7:0] acc_addr, acc_wdata;
    logic acc_we;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dmem_req === 1'b1) begin
                if (!in_acc) begin
                    in_acc = 1; acc_cnt = 1;
                    acc_addr = dmem_addr; acc_we = dmem_we; acc_wdata = dmem_wdata;
                end else begin
                    acc_cnt++;
                    if (dmem_addr !== acc_addr || dmem_we !== acc_we || dmem_wdata !== acc_wdata)
                        unstable++;
                end
                dmem_ready = (acc_cnt >= mem_k);
                dmem_rdata = mem[dmem_addr];
            end else begin
                in_acc = 0;
                if (dmem_we !== 1'b0) we_viol++;
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = 8'($urandom);
            end
        end
    end

    always @(posedge clk) begin
        if (dmem_req === 1'b1 && dmem_ready === 1'b1 && dmem_we === 1'b1) begin
            mem[dmem_addr] = dmem_wdata;
            wr_cnt++;
        end
    end

    // ISA-level reference model
    logic [7:0] m_reg [32];
    logic [7:0] m_mem [256];
    logic [5:0] m_pc;
    logic       m_z, m_c, m_halt;
    logic [7:0] m_out;

    function automatic logic [ISIZE-1:0] enc(int op, int rd, int rs, int imm);
        return {6'(op), 5'(rd), 5'(rs), 8'(imm)};
    endfunction

    task automatic m_reset();
        m_pc = 0; m_z = 0; m_c = 0; m_halt = 0; m_out = 0;
    endtask

    task automatic m_exec(input logic [ISIZE-1:0] ins, input logic [7:0] inval, input int k,
                          output int cycles, output bit is_mem, output bit is_st,
                          output logic [7:0] eaddr, output logic [7:0] ewdata);
        int op, rd, rs, imm, a, b, r, npc;
        bit wr;
        op = int'(ins[23:18]); rd = int'(ins[17:13]); rs = int'(ins[12:8]); imm = int'(ins[7:0]);
        a = int'(m_reg[rd]); b = (op >= 9) ? imm : int'(m_reg[rs]);
        cycles = 2; is_mem = 0; is_st = 0; eaddr = 0; ewdata = 0; wr = 0; r = 0;
        npc = (int'(m_pc) + 1) % 64;
        case (op)
            1, 9:   begin r = a + b; m_c = (r > 255); end
            2, 10:  begin r = a - b; m_c = (a < b); end
            3, 11:  begin r = a & b; m_c = 0; end
            4, 12:  begin r = a | b; m_c = 0; end
            5, 13:  begin r = a ^ b; m_c = 0; end
            14:     begin r = imm; wr = 1; end
            16: begin
                eaddr = 8'((int'(m_reg[rs]) + imm) % 256);
                r = int'(m_mem[eaddr]); wr = 1; is_mem = 1; cycles = 2 + k;
            end
            17: begin
                eaddr = 8'((int'(m_reg[rs]) + imm) % 256);
                ewdata = m_reg[rd]; m_mem[eaddr] = ewdata;
                is_mem = 1; is_st = 1; cycles = 2 + k;
            end
            18: begin r = int'(inval); wr = 1; end
            19: m_out = m_reg[rd];
            32: if (m_z) npc = imm % 64;
            33: if (!m_z) npc = imm % 64;
            34: npc = imm % 64;
            63: begin m_halt = 1; npc = int'(m_pc); end
            default: ;
        endcase
        if ((op >= 1 && op <= 5) || (op >= 9 && op <= 13)) begin
            r = r & 255; m_z = (r == 0); wr = 1;
        end
        if (wr && rd != 0) m_reg[rd] = 8'(r);
        m_pc = 6'(npc);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        m_reset();
    endtask

    // Run one instruction on both DUT and model; kf > 0 forces the memory latency.
    task automatic step(input string tag, input int kf);
        logic [ISIZE-1:0] ins;
        logic [7:0] inval, ea, ew;
        int cyc, k;
        bit im, ist;
        ins = rom[m_pc];
        inval = 8'($urandom);
        inport = inval;
        k = (kf > 0) ? kf : int'($urandom_range(1, 4));
        mem_k = k;
        m_exec(ins, inval, k, cyc, im, ist, ea, ew);
        repeat (cyc) @(posedge clk);
        #1;
        n_checks++;
        if (imem_addr !== m_pc) begin
            n_fail++; $display("FAIL %s pc: got %0h expected %0h", tag, imem_addr, m_pc);
        end
        n_checks++;
        if (outport !== m_out) begin
            n_fail++; $display("FAIL %s outport: got %0h expected %0h", tag, outport, m_out);
        end
        n_checks++;
        if (halted !== m_halt) begin
            n_fail++; $display("FAIL %s halted: got %0b expected %0b", tag, halted, m_halt);
        end
        n_checks++;
        if (dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL %s req_idle: got %0b expected 0", tag, dmem_req);
        end
        if (im) begin
            n_checks++;
            if (acc_addr !== ea || acc_we !== ist || acc_cnt != k) begin
                n_fail++;
                $display("FAIL %s mem_access: got addr %0h we %0b cycles %0d expected addr %0h we %0b cycles %0d",
                         tag, acc_addr, acc_we, acc_cnt, ea, ist, k);
            end
            if (ist) begin
                n_checks++;
                if (mem[ea] !== ew || acc_wdata !== ew) begin
                    n_fail++;
                    $display("FAIL %s store_data: got %0h (mem %0h) expected %0h", tag, acc_wdata, mem[ea], ew);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (imem_addr !== 6'd0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 8'd0 ||
            dmem_wdata !== 8'd0 || outport !== 8'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got pc %0h req %0b we %0b addr %0h wdata %0h out %0h halted %0b expected all 0",
                     imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, outport, halted);
        end
        reset = 1;
        m_reset();
        mon_en = 1;
    endtask

    task automatic test_basic();
        clear_rom();
        rom[0] = enc(6'h0E, 1, 0, 5);
        rom[1] = enc(6'h0E, 2, 0, 3);
        rom[2] = enc(6'h01, 1, 2, 0);
        rom[3] = enc(6'h13, 1, 0, 0);
        rom[4] = enc(6'h20, 0, 0, 10);
        rom[5] = enc(6'h3F, 0, 0, 0);
        rom[10] = enc(6'h3F, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step("basic", 0);
        n_checks++;
        if (outport !== 8'd8) begin
            n_fail++; $display("FAIL basic_sum: got %0h expected 8", outport);
        end
        step("basic_beq_not_taken", 0);
        step("basic_halt", 0);
    endtask

    task automatic test_carry();
        clear_rom();
        rom[0] = enc(6'h0E, 1, 0, 8'hFF);
        rom[1] = enc(6'h09, 1, 0, 1);
        rom[2] = enc(6'h20, 0, 0, 4);
        rom[3] = enc(6'h3F, 0, 0, 0);
        rom[4] = enc(6'h13, 1, 0, 0);
        rom[5] = enc(6'h0A, 1, 0, 1);
        rom[6] = enc(6'h20, 0, 0, 9);
        rom[7] = enc(6'h13, 1, 0, 0);
        rom[8] = enc(6'h3F, 0, 0, 0);
        rom[9] = enc(6'h3F, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step("carry", 0);
        n_checks++;
        if (outport !== 8'h00 || imem_addr !== 6'd5) begin
            n_fail++; $display("FAIL carry_wrap: got out %0h pc %0h expected out 0 pc 5", outport, imem_addr);
        end
        for (int i = 0; i < 4; i++) step("carry", 0);
        n_checks++;
        if (outport !== 8'hFF || halted !== 1'b1) begin
            n_fail++; $display("FAIL borrow_wrap: got out %0h halted %0b expected out ff halted 1", outport, halted);
        end
    endtask

    task automatic test_loop();
        clear_rom();
        rom[0] = enc(6'h0E, 1, 0, 3);
        rom[1] = enc(6'h0A, 1, 0, 1);
        rom[2] = enc(6'h21, 0, 0, 1);
        rom[3] = enc(6'h3F, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 8; i++) step("loop", 0);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (imem_addr !== 6'd3 || halted !== 1'b1) begin
            n_fail++; $display("FAIL loop_frozen: got pc %0h halted %0b expected pc 3 halted 1", imem_addr, halted);
        end
    endtask

    task automatic test_mem();
        int w0;
        clear_rom();
        rom[0] = enc(6'h0E, 3, 0, 8'hA5);
        rom[1] = enc(6'h0E, 4, 0, 8'h10);
        rom[2] = enc(6'h11, 3, 4, 2);
        rom[3] = enc(6'h10, 5, 4, 2);
        rom[4] = enc(6'h13, 5, 0, 0);
        rom[5] = enc(6'h3F, 0, 0, 0);
        mem[8'h12] = 8'h00; m_mem[8'h12] = 8'h00;
        do_reset();
        w0 = wr_cnt;
        step("mem_ldi", 0);
        step("mem_ldi", 0);
        step("mem_sw", 3);
        step("mem_lw", 1);
        step("mem_out", 0);
        n_checks++;
        if (wr_cnt - w0 != 1 || outport !== 8'hA5) begin
            n_fail++; $display("FAIL mem_roundtrip: got writes %0d out %0h expected writes 1 out a5", wr_cnt - w0, outport);
        end
        step("mem_halt", 0);
    endtask

    task automatic test_r0_unknown_wrap();
        clear_rom();
        rom[0] = enc(6'h0E, 0, 0, 7);
        rom[1] = enc(6'h13, 0, 0, 0);
        rom[2] = enc(6'h0E, 1, 0, 8'h5A);
        rom[3] = enc(6'h15, 1, 2, 8'hFF);
        rom[4] = enc(6'h13, 1, 0, 0);
        do_reset();
        step("r0_ldi", 0);
        step("r0_out", 0);
        n_checks++;
        if (outport !== 8'h00) begin
            n_fail++; $display("FAIL r0_zero: got %0h expected 0", outport);
        end
        step("unk_ldi", 0);
        step("unk_op", 0);
        step("unk_out", 0);
        n_checks++;
        if (outport !== 8'h5A) begin
            n_fail++; $display("FAIL unknown_op: got %0h expected 5a", outport);
        end
        for (int i = 5; i < 64; i++) step("wrap", 0);
        n_checks++;
        if (imem_addr !== 6'd0) begin
            n_fail++; $display("FAIL pc_wrap: got %0h expected 0", imem_addr);
        end
    endtask

    task automatic test_reset_mid_access();
        clear_rom();
        rom[0] = enc(6'h22, 0, 0, 4);
        rom[4] = enc(6'h0E, 5, 0, 8'h33);
        rom[5] = enc(6'h10, 5, 0, 8'h40);
        rom[6] = enc(6'h3F, 0, 0, 0);
        mem[8'h40] = 8'hEE; m_mem[8'h40] = 8'hEE;
        do_reset();
        step("mid_j", 0);
        step("mid_ldi", 0);
        mem_k = 1000;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 8'h40) begin
            n_fail++; $display("FAIL mid_in_mem: got req %0b addr %0h expected req 1 addr 40", dmem_req, dmem_addr);
        end
        reset = 0;
        @(posedge clk);
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_addr !== 6'd0 || dmem_addr !== 8'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got req %0b we %0b pc %0h addr %0h halted %0b expected all 0",
                     dmem_req, dmem_we, imem_addr, dmem_addr, halted);
        end
        clear_rom();
        rom[0] = enc(6'h13, 5, 0, 0);
        rom[1] = enc(6'h3F, 0, 0, 0);
        reset = 1;
        m_reset();
        step("mid_out", 0);
        n_checks++;
        if (outport !== 8'h33) begin
            n_fail++; $display("FAIL mid_no_write: got %0h expected 33", outport);
        end
        step("mid_halt", 0);
    endtask

    task automatic test_random();
        int ops [21];
        int op, steps;
        ops = '{1, 2, 3, 4, 5, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 0, 32, 33, 34, 21, 42};
        for (int p = 0; p < 5; p++) begin
            for (int a = 0; a < 256; a++) begin
                mem[a] = 8'($urandom); m_mem[a] = mem[a];
            end
            clear_rom();
            for (int i = 0; i < 7; i++) rom[i] = enc(14, i + 1, 0, int'($urandom_range(0, 255)));
            for (int i = 7; i < 56; i++) begin
                op = ops[$urandom_range(0, 20)];
                if (op >= 32 && op <= 34)
                    rom[i] = enc(op, 0, 0, int'($urandom_range(56, i + 1)));
                else
                    rom[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                 int'($urandom_range(0, 255)));
            end
            for (int i = 56; i < 64; i++) rom[i] = enc(63, 0, 0, 0);
            do_reset();
            steps = 0;
            while (!m_halt && steps < 80) begin
                step("random", 0);
                steps++;
            end
            n_checks++;
            if (halted !== 1'b1) begin
                n_fail++; $display("FAIL random_end: got halted %0b expected 1 after %0d steps", halted, steps);
            end
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (we_viol != 0 || unstable != 0) begin
            n_fail++; $display("FAIL protocol: got we_idle %0d unstable %0d expected 0 and 0", we_viol, unstable);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'h00; m_mem[a] = 8'h00;
        end
        clear_rom();
        test_reset();
        test_basic();
        test_carry();
        test_loop();
        test_mem();
        test_r0_unknown_wrap();
        test_reset_mid_access();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
